// File: rtl/miner_pkg.sv
// Constants and types shared by the miner front end: header geometry, clocking and receive states.
package miner_pkg;

  localparam int unsigned HEADER_BYTES = 80;
  localparam int unsigned HEADER_BITS  = 640;
  localparam int unsigned NONCE_BITS   = 32;
  localparam int unsigned CLK_HZ       = 50_000_000;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

endpackage

// File: rtl/header_rx_assembler_if.sv
// Byte stream from the UART plus the assembled header handed to the miner.
interface header_rx_assembler_if #(
  parameter int unsigned HEADER_BYTES = miner_pkg::HEADER_BYTES
);
  localparam int unsigned BCW = $clog2(HEADER_BYTES);

  logic [7:0]                rx_byte;
  logic                      rx_ready;
  logic                      rdy_clr;
  logic [8*HEADER_BYTES-1:0] header_data;
  logic                      header_valid;
  logic                      header_ack;
  logic [BCW-1:0]            byte_count;
  logic                      overrun;
  logic                      timeout_err;

  // master: UART/miner side; slave: the assembler
  modport master (
    output rx_byte, rx_ready, header_ack,
    input  rdy_clr, header_data, header_valid, byte_count, overrun, timeout_err
  );

  modport slave (
    input  rx_byte, rx_ready, header_ack,
    output rdy_clr, header_data, header_valid, byte_count, overrun, timeout_err
  );
endinterface

// File: rtl/rx_byte_handshake.sv
// Level-to-pulse handshake with a UART rdy flag: one accept strobe per byte, rdy_clr pulse the cycle after.
module rx_byte_handshake (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_ready_i,
  output logic rdy_clr_o,
  output logic byte_accept_o
);

  logic armed_q, armed_d;
  logic rdy_clr_q;

  assign byte_accept_o = rx_ready_i & armed_q;
  assign rdy_clr_o     = rdy_clr_q;

  // Re-arm only once rdy has been seen low, so a slow rdy_clr round trip cannot double-accept.
  always_comb begin
    armed_d = armed_q;
    if (!rx_ready_i)        armed_d = 1'b1;
    else if (byte_accept_o) armed_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed_q   <= 1'b0;
      rdy_clr_q <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      rdy_clr_q <= byte_accept_o;
    end
  end

endmodule

// File: rtl/header_rx_assembler.sv
// Assembles UART bytes into a block header for the miner, with overrun flagging and inter-byte timeout.
module header_rx_assembler #(
  parameter int unsigned HEADER_BYTES   = miner_pkg::HEADER_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic                  clock,
  input logic                  reset,
  header_rx_assembler_if.slave bus
);
  import miner_pkg::*;

  localparam int unsigned HBITS = 8 * HEADER_BYTES;
  localparam int unsigned BCW   = $clog2(HEADER_BYTES);
  localparam int unsigned IW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(HEADER_BYTES - 1);
  localparam logic [IW-1:0]  IDLE_MAX  = IW'(TIMEOUT_CYCLES - 1);

  rx_state_e        state_q, state_d;
  logic [HBITS-9:0] shift_q;
  logic [HBITS-1:0] header_q;
  logic             valid_q;
  logic [BCW-1:0]   count_q;
  logic [IW-1:0]    idle_q;
  logic             overrun_q;
  logic             timeout_q;
  logic             byte_accept;
  logic             rdy_clr;
  logic             complete;
  logic             timeout_hit;

  rx_byte_handshake u_handshake (
    .clk_i         (clock),
    .rst_ni        (reset),
    .rx_ready_i    (bus.rx_ready),
    .rdy_clr_o     (rdy_clr),
    .byte_accept_o (byte_accept)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (byte_accept)              state_d = RECV;
      RECV: if (complete || timeout_hit)  state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // An accept on the would-be timeout cycle wins: the byte counts and no timeout fires.
  always_comb begin
    complete    = 1'b0;
    timeout_hit = 1'b0;
    if (byte_accept)          complete    = (count_q == LAST_BYTE);
    else if (state_q == RECV) timeout_hit = (idle_q == IDLE_MAX);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q   <= '0;
      header_q  <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
      idle_q    <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (byte_accept) begin
        shift_q <= {shift_q[HBITS-17:0], bus.rx_byte};
        idle_q  <= '0;
        count_q <= complete ? '0 : count_q + 1'b1;
      end else if (timeout_hit) begin
        count_q <= '0;
        idle_q  <= '0;
      end else if (state_q == RECV) begin
        idle_q  <= idle_q + 1'b1;
      end

      if (complete) begin
        header_q <= {shift_q, bus.rx_byte};
        valid_q  <= 1'b1;
        if (valid_q && !bus.header_ack) overrun_q <= 1'b1;
      end else if (bus.header_ack && valid_q) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.rdy_clr      = rdy_clr;
  assign bus.header_data  = header_q;
  assign bus.header_valid = valid_q;
  assign bus.byte_count   = count_q;
  assign bus.overrun      = overrun_q;
  assign bus.timeout_err  = timeout_q;

endmodule
